// File: rtl/clock_time_counter_pkg.sv
// ============================================================================
// Module      : clock_time_counter_pkg
// Description : Field widths, moduli and default initial time for the clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clock_time_counter_pkg;

    localparam int c_HOUR_W = 5;
    localparam int c_MIN_W  = 6;
    localparam int c_SEC_W  = 6;
    localparam int c_CSEC_W = 7;

    localparam int c_HOUR_MOD = 24;
    localparam int c_MIN_MOD  = 60;
    localparam int c_SEC_MOD  = 60;
    localparam int c_CSEC_MOD = 100;

    localparam int c_DEF_INIT_HOUR = 12;
    localparam int c_DEF_INIT_MIN  = 0;

endpackage

`default_nettype wire

// File: rtl/clock_time_counter_digit.sv
// ============================================================================
// Module      : time_digit_cnt
// Description : Modulo-N up/down counter with clear, load and wrap carry-out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module time_digit_cnt #(
    parameter int MODULUS = 60,
    parameter int WIDTH   = 6,
    parameter int INIT    = 0
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iClr,
    input  logic             iLoad,
    input  logic [WIDTH-1:0] iLoadVal,
    input  logic             iInc,
    input  logic             iDec,
    output logic [WIDTH-1:0] oVal,
    output logic             oCarry
);

    localparam logic [WIDTH-1:0] c_LAST = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] c_INIT = WIDTH'(INIT);

    logic [WIDTH-1:0] r_val;
    logic             w_up;
    logic             w_down;

    // Simultaneous up and down cancel; clear and load take priority.
    assign w_up   = iInc & ~iDec & ~iClr & ~iLoad;
    assign w_down = iDec & ~iInc & ~iClr & ~iLoad;
    assign oCarry = w_up & (r_val == c_LAST);
    assign oVal   = r_val;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_val <= c_INIT;
        end else if (iClr) begin
            r_val <= '0;
        end else if (iLoad) begin
            if (iLoadVal <= c_LAST) begin
                r_val <= iLoadVal;
            end
        end else if (w_up) begin
            r_val <= (r_val == c_LAST) ? '0 : r_val + 1'b1;
        end else if (w_down) begin
            r_val <= (r_val == '0) ? c_LAST : r_val - 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/clock_time_counter.sv
// ============================================================================
// Module      : clock_time_counter
// Description : HH:MM:SS.cc time-of-day counter with set mode and edit blink.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_time_counter
    import clock_time_counter_pkg::*;
#(
    parameter int P_INIT_HOUR   = c_DEF_INIT_HOUR,
    parameter int P_INIT_MIN    = c_DEF_INIT_MIN,
    parameter int P_BLINK_TICKS = 50
) (
    input  logic                iClk,
    input  logic                iRst_n,
    input  logic                iTick_100Hz,
    input  logic                iHour_Up,
    input  logic                iHour_Down,
    input  logic                iMin_Up,
    input  logic                iMin_Down,
    input  logic                iSet_Hour,
    input  logic                iSet_Min,
    output logic [c_HOUR_W-1:0] oHour,
    output logic [c_MIN_W-1:0]  oMin,
    output logic [c_SEC_W-1:0]  oSec,
    output logic [c_CSEC_W-1:0] oCsec,
    output logic                oBlink_Hour,
    output logic                oBlink_Min
);

    localparam int c_BLINK_W = (P_BLINK_TICKS > 1) ? $clog2(P_BLINK_TICKS) : 1;
    localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(P_BLINK_TICKS - 1);

    logic                 w_setMode;
    logic                 w_csecCarry;
    logic                 w_secCarry;
    logic                 w_minCarry;
    logic                 w_unusedDayCarry;
    logic                 w_minInc;
    logic                 w_minDec;
    logic                 w_hourInc;
    logic                 w_hourDec;
    logic                 w_entry;
    logic [c_BLINK_W-1:0] w_cntNext;
    logic                 w_phaseNext;

    logic [c_BLINK_W-1:0] r_blinkCnt;
    logic                 r_phase;
    logic                 r_setHourD;
    logic                 r_setMinD;
    logic                 r_blinkHour;
    logic                 r_blinkMin;

    assign w_setMode = iSet_Hour | iSet_Min;

    // In set mode edit strobes replace the carry chain, so a minute wrap never reaches the hour.
    assign w_minInc  = w_setMode ? iMin_Up  : w_secCarry;
    assign w_minDec  = w_setMode & iMin_Down;
    assign w_hourInc = w_setMode ? iHour_Up : w_minCarry;
    assign w_hourDec = w_setMode & iHour_Down;

    time_digit_cnt #(.MODULUS(c_CSEC_MOD), .WIDTH(c_CSEC_W), .INIT(0)) u_csec (
        .iClk(iClk), .iRst_n(iRst_n), .iClr(w_setMode), .iLoad(1'b0), .iLoadVal('0),
        .iInc(iTick_100Hz & ~w_setMode), .iDec(1'b0), .oVal(oCsec), .oCarry(w_csecCarry)
    );

    time_digit_cnt #(.MODULUS(c_SEC_MOD), .WIDTH(c_SEC_W), .INIT(0)) u_sec (
        .iClk(iClk), .iRst_n(iRst_n), .iClr(w_setMode), .iLoad(1'b0), .iLoadVal('0),
        .iInc(w_csecCarry), .iDec(1'b0), .oVal(oSec), .oCarry(w_secCarry)
    );

    time_digit_cnt #(.MODULUS(c_MIN_MOD), .WIDTH(c_MIN_W), .INIT(P_INIT_MIN)) u_min (
        .iClk(iClk), .iRst_n(iRst_n), .iClr(1'b0), .iLoad(1'b0), .iLoadVal('0),
        .iInc(w_minInc), .iDec(w_minDec), .oVal(oMin), .oCarry(w_minCarry)
    );

    time_digit_cnt #(.MODULUS(c_HOUR_MOD), .WIDTH(c_HOUR_W), .INIT(P_INIT_HOUR)) u_hour (
        .iClk(iClk), .iRst_n(iRst_n), .iClr(1'b0), .iLoad(1'b0), .iLoadVal('0),
        .iInc(w_hourInc), .iDec(w_hourDec), .oVal(oHour), .oCarry(w_unusedDayCarry)
    );

    // Entering either edit field restarts the blink with the field visible.
    assign w_entry = (iSet_Hour & ~r_setHourD) | (iSet_Min & ~r_setMinD);

    always_comb begin
        w_cntNext   = r_blinkCnt;
        w_phaseNext = r_phase;
        if (w_entry) begin
            w_cntNext   = '0;
            w_phaseNext = 1'b0;
        end else if (iTick_100Hz) begin
            if (r_blinkCnt == c_BLINK_LAST) begin
                w_cntNext   = '0;
                w_phaseNext = ~r_phase;
            end else begin
                w_cntNext = r_blinkCnt + 1'b1;
            end
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_blinkCnt  <= '0;
            r_phase     <= 1'b0;
            r_setHourD  <= 1'b0;
            r_setMinD   <= 1'b0;
            r_blinkHour <= 1'b0;
            r_blinkMin  <= 1'b0;
        end else begin
            r_blinkCnt  <= w_cntNext;
            r_phase     <= w_phaseNext;
            r_setHourD  <= iSet_Hour;
            r_setMinD   <= iSet_Min;
            r_blinkHour <= iSet_Hour & w_phaseNext;
            r_blinkMin  <= iSet_Min & w_phaseNext;
        end
    end

    assign oBlink_Hour = r_blinkHour;
    assign oBlink_Min  = r_blinkMin;

endmodule

`default_nettype wire

// File: tb/tb_clock_time_counter.sv
// ============================================================================
// Module      : tb_clock_time_counter
// Description : Scoreboard bench for clock_time_counter against a time model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clock_time_counter;

    logic       iClk = 1'b0;
    logic       iRst_n;
    logic       iTick_100Hz, iHour_Up, iHour_Down, iMin_Up, iMin_Down, iSet_Hour, iSet_Min;
    logic [4:0] oHour;
    logic [5:0] oMin, oSec;
    logic [6:0] oCsec;
    logic       oBlink_Hour, oBlink_Min;

    typedef logic [25:0] obs_t;

    obs_t sbQ[$];
    obs_t dutObs;
    int   nChecks = 0;
    int   nFails  = 0;
    int   mh, mm, ms, mc, bcnt, phase, prevSh, prevSm;

    localparam int c_BLINK = 50;

    clock_time_counter dut (
        .iClk(iClk), .iRst_n(iRst_n), .iTick_100Hz(iTick_100Hz),
        .iHour_Up(iHour_Up), .iHour_Down(iHour_Down), .iMin_Up(iMin_Up), .iMin_Down(iMin_Down),
        .iSet_Hour(iSet_Hour), .iSet_Min(iSet_Min),
        .oHour(oHour), .oMin(oMin), .oSec(oSec), .oCsec(oCsec),
        .oBlink_Hour(oBlink_Hour), .oBlink_Min(oBlink_Min)
    );

    always #5 iClk = ~iClk;

    assign dutObs = {oHour, oMin, oSec, oCsec, oBlink_Hour, oBlink_Min};

    task automatic checkVal(string tag, logic [31:0] obs, logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic obs_t packTime(int h, int m, int s, int c, int bh, int bm);
        return {5'(h), 6'(m), 6'(s), 7'(c), 1'(bh), 1'(bm)};
    endfunction

    function automatic void modelReset();
        mh = 12; mm = 0; ms = 0; mc = 0;
        bcnt = 0; phase = 0; prevSh = 0; prevSm = 0;
    endfunction

    function automatic obs_t modelStep(bit tick, bit hu, bit hd, bit mu, bit md, bit sh, bit sm);
        if (sh || sm) begin
            ms = 0;
            mc = 0;
            if (hu && !hd) mh = (mh + 1) % 24;
            if (hd && !hu) mh = (mh + 23) % 24;
            if (mu && !md) mm = (mm + 1) % 60;
            if (md && !mu) mm = (mm + 59) % 60;
        end else if (tick) begin
            mc++;
            if (mc == 100) begin
                mc = 0; ms++;
                if (ms == 60) begin
                    ms = 0; mm++;
                    if (mm == 60) begin
                        mm = 0; mh = (mh + 1) % 24;
                    end
                end
            end
        end
        if ((sh && !prevSh) || (sm && !prevSm)) begin
            bcnt = 0; phase = 0;
        end else if (tick) begin
            if (bcnt == c_BLINK - 1) begin
                bcnt = 0; phase = 1 - phase;
            end else begin
                bcnt++;
            end
        end
        prevSh = sh;
        prevSm = sm;
        return packTime(mh, mm, ms, mc, (sh && phase != 0) ? 1 : 0, (sm && phase != 0) ? 1 : 0);
    endfunction

    task automatic step(string tag, bit tick, bit hu, bit hd, bit mu, bit md);
        iTick_100Hz = tick; iHour_Up = hu; iHour_Down = hd; iMin_Up = mu; iMin_Down = md;
        sbQ.push_back(modelStep(tick, hu, hd, mu, md, iSet_Hour, iSet_Min));
        @(posedge iClk);
        #1;
        if (sbQ.size() == 0) checkVal("sbUnderflow", 0, 1);
        else checkVal(tag, dutObs, sbQ.pop_front());
        iTick_100Hz = 0; iHour_Up = 0; iHour_Down = 0; iMin_Up = 0; iMin_Down = 0;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        int toggles;
        logic lastBlink;
        iRst_n = 0; iTick_100Hz = 0; iHour_Up = 0; iHour_Down = 0;
        iMin_Up = 0; iMin_Down = 0; iSet_Hour = 0; iSet_Min = 0;
        modelReset();
        #12;
        checkVal("reset", dutObs, packTime(12, 0, 0, 0, 0, 0));
        @(negedge iClk);
        iRst_n = 1;

        for (int i = 0; i < 100; i++) begin
            step("run", 1, 0, 0, 0, 0);
            step("idle", 0, 0, 0, 0, 0);
        end
        checkVal("t100", dutObs, packTime(12, 0, 1, 0, 0, 0));

        step("runEdit", 0, 1, 0, 1, 0);
        step("runEdit", 0, 0, 1, 0, 1);

        iSet_Hour = 1; step("enterH", 0, 0, 0, 0, 0);
        for (int i = 0; i < 11; i++) step("hourUp", 0, 1, 0, 0, 0);
        iSet_Hour = 0; step("leaveH", 0, 0, 0, 0, 0);
        iSet_Min = 1; step("enterM", 0, 0, 0, 0, 0);
        step("minDown", 0, 0, 0, 0, 1);
        iSet_Min = 0; step("leaveM", 0, 0, 0, 0, 0);
        checkVal("preload", dutObs, packTime(23, 59, 0, 0, 0, 0));
        for (int i = 0; i < 5999; i++) step("toEnd", 1, 0, 0, 0, 0);
        checkVal("preRoll", dutObs, packTime(23, 59, 59, 99, 0, 0));
        step("roll", 1, 0, 0, 0, 0);
        checkVal("rollover", dutObs, packTime(0, 0, 0, 0, 0, 0));

        iSet_Min = 1; step("enterM2", 0, 0, 0, 0, 0);
        step("minDown0", 0, 0, 0, 0, 1);
        checkVal("minWrapDown", dutObs, packTime(0, 59, 0, 0, 0, 0));
        step("minUp59", 0, 0, 0, 1, 0);
        checkVal("minWrapUp", dutObs, packTime(0, 0, 0, 0, 0, 0));
        step("minBoth", 0, 0, 0, 1, 1);
        iSet_Min = 0; step("leaveM2", 0, 0, 0, 0, 0);

        iSet_Hour = 1; step("enterH2", 0, 0, 0, 0, 0);
        step("hourBoth", 0, 1, 1, 0, 0);
        checkVal("hourBothHold", dutObs, packTime(0, 0, 0, 0, 0, 0));
        step("hourDown0", 0, 0, 1, 0, 0);
        checkVal("hourWrapDown", dutObs, packTime(23, 0, 0, 0, 0, 0));
        iSet_Hour = 0; step("leaveH2", 0, 0, 0, 0, 0);

        for (int i = 0; i < 3; i++) step("runPre", 1, 0, 0, 0, 0);
        iSet_Hour = 1; step("enterBlink", 0, 0, 0, 0, 0);
        toggles = 0;
        lastBlink = oBlink_Hour;
        for (int i = 0; i < 200; i++) begin
            step("blink", 1, 0, 0, 0, 0);
            if (oBlink_Hour !== lastBlink) toggles++;
            lastBlink = oBlink_Hour;
        end
        checkVal("blinkToggles", toggles, 4);
        iSet_Hour = 0; step("leaveBlink", 0, 0, 0, 0, 0);
        step("resume", 1, 0, 0, 0, 0);
        checkVal("resume", dutObs, packTime(23, 0, 0, 1, 0, 0));

        iSet_Hour = 1; step("enterH3", 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) step("toSeven", 0, 0, 1, 0, 0);
        for (int i = 0; i < 15; i++) step("to45", 0, 0, 0, 0, 1);
        checkVal("at0745", dutObs, packTime(7, 45, 0, 0, 0, 0));
        #2;
        iRst_n = 0;
        #1;
        checkVal("asyncRst", dutObs, packTime(12, 0, 0, 0, 0, 0));
        modelReset();
        @(negedge iClk);
        @(negedge iClk);
        iRst_n = 1;
        step("postRst", 0, 0, 0, 0, 0);
        iSet_Hour = 0; step("leaveH3", 0, 0, 0, 0, 0);
        step("firstTick", 1, 0, 0, 0, 0);
        checkVal("firstTick", dutObs, packTime(12, 0, 0, 1, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule

`default_nettype wire
